snapshot_dumper: RTL
====================

Name: snapshot_dumper

Overview:
- Synthesizable successor to the per-cycle register and memory print loop used around the RV32I pipeline.
- On a trigger, captures a cycle-count header, then reads NREG register-file entries and NWORD little-endian memory words from byte-wide data memory.
- Streams each item out on a valid/ready port for a debug UART/trace sink.
- Sits beside the pipeline, using spare read ports on the register file and data memory.

Parameters:
- XLEN, 32: data width of register and assembled memory words.
- NREG, 32: registers dumped, indices 0..NREG-1 (1..2^RAW).
- RAW, 5: register-file address width.
- NWORD, 8: memory words dumped (>=1).
- MAW, 10: data-memory byte-address width.
- MEM_BASE, 0: byte address of the first dumped word, 4-aligned.
- CNT_W, 32: cycle-counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- trig  in  1  start-snapshot pulse.
- cont  in  1  1 = re-arm automatically after each snapshot.
- clr_ovr  in  1  clears the overrun flag.
- rf_raddr  out  RAW  register-file read address.
- rf_rdata  in  XLEN  combinational register read data.
- dm_raddr  out  MAW  data-memory byte read address.
- dm_rdata  in  8  combinational byte read data.
- out_valid  out  1  stream item valid.
- out_ready  in  1  sink accepts.
- out_data  out  XLEN  item payload.
- out_tag  out  2  0 = header, 1 = register, 2 = memory word.
- out_idx  out  16  register or word index; 0 for the header.
- busy  out  1  snapshot in progress.
- done  out  1  one-cycle pulse when a snapshot completes.
- overrun  out  1  sticky: a trigger arrived while busy.
- cycle_cnt  out  CNT_W  free-running cycle count.

Behaviour:
- Reset (rst=0, async): every output and internal register is 0; state = IDLE. A reset asserted mid-snapshot aborts it with no further items and no done pulse.
- cycle_cnt:
  - Increments every clk, wrapping modulo 2^CNT_W.
  - Reads 0 in the first cycle after reset release.
- IDLE:
  - busy=0, out_valid=0.
  - trig=1, or cont=1 with the previous snapshot just done, latches cycle_cnt into snap_cnt and moves to HDR.
  - out_valid rises the following cycle.
- HDR:
  - out_valid=1, out_tag=0, out_idx=0, out_data=snap_cnt zero-extended/truncated to XLEN.
  - On valid&ready, set idx=0 and go to RFETCH.
- RFETCH:
  - One cycle: rf_raddr=idx; rf_rdata is registered into out_data; go to RSEND.
- RSEND:
  - out_valid=1, tag=1, out_idx=idx.
  - On handshake: if idx==NREG-1, set idx=0, byte=0 and go to MFETCH; else idx++ and go to RFETCH.
- MFETCH:
  - Four cycles, byte b=0..3.
  - dm_raddr = (MEM_BASE + 4*idx + b) mod 2^MAW.
  - dm_rdata is written into out_data[8b+7:8b] (little-endian).
  - After b=3, go to MSEND.
- MSEND:
  - out_valid=1, tag=2, out_idx=idx.
  - On handshake: if idx==NWORD-1, go to IDLE and pulse done the next cycle; else idx++ and go to MFETCH.
- Stream rules:
  - While out_valid=1 and out_ready=0, out_data, out_tag and out_idx hold stable and out_valid stays high.
  - out_valid never drops without a handshake.
- Latency: with out_ready held at 1, a trig at cycle t produces done at t + 1 + 2*NREG + 5*NWORD + 1.
  - Defaults give t+106.
- Trigger handling:
  - A trig while busy is ignored and sets overrun.
  - clr_ovr clears overrun; if clr_ovr and a new overrun occur in the same cycle, set wins.
  - A trig in the same cycle as done is a valid new start; busy stays 1 and overrun is not set.
- Address generation: rf_raddr and dm_raddr hold 0 outside their fetch states.

Test Plan:
- Reset behaviour: assert rst=0 for 3 cycles mid-MFETCH, then release -> all outputs 0, no done pulse, cycle_cnt reads 0 then 1 on successive cycles.
- Full dump, default parameters:
  - Stimulus: registers preloaded regs[i]=i; memory bytes mem[k]=k; out_ready=1; trig at cycle 10.
  - Response: header data=10; then 32 register items with data=i; then 8 memory items with word0=32'h03020100 and word7=32'h1F1E1D1C; done at cycle 116.
- Backpressure: out_ready=0 for 7 cycles during RSEND of idx 5 -> out_valid, data=5 and idx=5 stay stable; the stream resumes in order with no loss or duplicate.
- Overrun:
  - trig again at busy cycle 20 -> overrun=1, snapshot unaffected.
  - clr_ovr and trig together while busy -> overrun stays 1.
- Continuous mode: cont=1, one trig -> three back-to-back snapshots, each header = latched cycle_cnt, spaced by 106 cycles with ready=1.
- Address wrap: MAW=4, MEM_BASE=12, NWORD=2 -> word1 byte addresses 0,1,2,3 (wrapped).

Source files
------------

// File: rtl/snapshot_dumper.sv
// Snapshot dumper: on a trigger, streams a cycle-count header, NREG register
// values and NWORD little-endian memory words over a valid/ready port.
module snapshot_dumper #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int RAW      = 5,
  parameter int NWORD    = 8,
  parameter int MAW      = 10,
  parameter int MEM_BASE = 0,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trig,
  input  logic             cont,
  input  logic             clr_ovr,
  output logic [RAW-1:0]   rf_raddr,
  input  logic [XLEN-1:0]  rf_rdata,
  output logic [MAW-1:0]   dm_raddr,
  input  logic [7:0]       dm_rdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_data,
  output logic [1:0]       out_tag,
  output logic [15:0]      out_idx,
  output logic             busy,
  output logic             done,
  output logic             overrun,
  output logic [CNT_W-1:0] cycle_cnt
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] HDR    = 3'd1;
  localparam logic [2:0] RFETCH = 3'd2;
  localparam logic [2:0] RSEND  = 3'd3;
  localparam logic [2:0] MFETCH = 3'd4;
  localparam logic [2:0] MSEND  = 3'd5;

  localparam logic [15:0]    LAST_REG  = 16'(NREG - 1);
  localparam logic [15:0]    LAST_WORD = 16'(NWORD - 1);
  localparam logic [MAW-1:0] BASE      = MAW'(MEM_BASE);

  logic [2:0]       state_reg;
  logic [15:0]      idx_reg;
  logic [1:0]       byte_reg;
  logic [XLEN-1:0]  data_reg;
  logic [CNT_W-1:0] snap_cnt_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             done_reg;
  logic             overrun_reg;
  logic [XLEN-1:0]  hdr_word;
  logic             start;

  generate
    if (CNT_W >= XLEN) begin : g_hdr_trunc
      assign hdr_word = snap_cnt_reg[XLEN-1:0];
    end else begin : g_hdr_ext
      assign hdr_word = {{(XLEN-CNT_W){1'b0}}, snap_cnt_reg};
    end
  endgenerate

  // done_reg is high exactly in the cycle the FSM has returned to IDLE, so
  // auto re-arm and a coincident trig both restart without a gap.
  assign start = (state_reg == IDLE) && (trig || (cont && done_reg));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      byte_reg     <= '0;
      data_reg     <= '0;
      snap_cnt_reg <= '0;
      cnt_reg      <= '0;
      done_reg     <= 1'b0;
      overrun_reg  <= 1'b0;
    end else begin
      cnt_reg  <= cnt_reg + 1'b1;
      done_reg <= 1'b0;
      if (trig && state_reg != IDLE)
        overrun_reg <= 1'b1;
      else if (clr_ovr)
        overrun_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (start) begin
            snap_cnt_reg <= cnt_reg;
            state_reg    <= HDR;
          end
        end
        HDR: begin
          if (out_ready) begin
            idx_reg   <= '0;
            state_reg <= RFETCH;
          end
        end
        RFETCH: begin
          data_reg  <= rf_rdata;
          state_reg <= RSEND;
        end
        RSEND: begin
          if (out_ready) begin
            if (idx_reg == LAST_REG) begin
              idx_reg   <= '0;
              byte_reg  <= '0;
              state_reg <= MFETCH;
            end else begin
              idx_reg   <= idx_reg + 16'd1;
              state_reg <= RFETCH;
            end
          end
        end
        MFETCH: begin
          // byte_reg wraps 3 -> 0, ready for the next word
          data_reg[{byte_reg, 3'b000} +: 8] <= dm_rdata;
          byte_reg <= byte_reg + 2'd1;
          if (byte_reg == 2'd3)
            state_reg <= MSEND;
        end
        MSEND: begin
          if (out_ready) begin
            if (idx_reg == LAST_WORD) begin
              state_reg <= IDLE;
              done_reg  <= 1'b1;
            end else begin
              idx_reg   <= idx_reg + 16'd1;
              state_reg <= MFETCH;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_comb begin
    out_valid = 1'b0;
    out_tag   = 2'd0;
    out_idx   = 16'd0;
    out_data  = data_reg;
    rf_raddr  = '0;
    dm_raddr  = '0;
    case (state_reg)
      HDR: begin
        out_valid = 1'b1;
        out_data  = hdr_word;
      end
      RFETCH: rf_raddr = idx_reg[RAW-1:0];
      RSEND: begin
        out_valid = 1'b1;
        out_tag   = 2'd1;
        out_idx   = idx_reg;
      end
      MFETCH: dm_raddr = BASE + MAW'({idx_reg, 2'b00}) + MAW'(byte_reg);
      MSEND: begin
        out_valid = 1'b1;
        out_tag   = 2'd2;
        out_idx   = idx_reg;
      end
      default: ;
    endcase
  end

  assign busy      = (state_reg != IDLE) || done_reg;
  assign done      = done_reg;
  assign overrun   = overrun_reg;
  assign cycle_cnt = cnt_reg;

endmodule
